pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 96 +++++++++
 tb/tb_pc_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_unit
// Brief    : Program counter with branch/jump/jr selection, kernel-mode flag,
//            pending-interrupt latch and exception/interrupt vectoring.
// Revision : 1.0
// ============================================================================
module pc_unit #(
  parameter logic [31:0] RESET_VEC = 32'h80000000,
  parameter logic [31:0] IRQ_VEC   = 32'h80000004,
  parameter logic [31:0] EXC_VEC   = 32'h80000008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic [1:0]  PCSrc,
  input  logic        BranchCond,
  input  logic [15:0] Imm16,
  input  logic [25:0] JTarget,
  input  logic [31:0] RsData,
  input  logic        IRQ,
  input  logic        Exception,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        pchigh,
  output logic        Interrupt
);

  localparam logic [1:0] SRC_SEQ    = 2'b00;
  localparam logic [1:0] SRC_BRANCH = 2'b01;
  localparam logic [1:0] SRC_JUMP   = 2'b10;
  localparam logic [1:0] SRC_JR     = 2'b11;

  logic [31:0] pc_q, pc_d;
  logic        irq_pend_q, irq_pend_d;
  logic        exc_take;
  logic [31:0] br_off, br_sum, br_target, next_pc;

  // The increment never touches bit 31: kernel mode is left only through jr.
  assign PCPlus4   = {pc_q[31], pc_q[30:0] + 31'd4};
  assign PC        = pc_q;
  assign pchigh    = pc_q[31];
  assign exc_take  = Exception & ~pchigh;
  assign Interrupt = irq_pend_q & ~pchigh & ~Exception & ~Stall;

  assign br_off    = {{14{Imm16[15]}}, Imm16, 2'b00};
  assign br_sum    = PCPlus4 + br_off;
  assign br_target = (br_sum & 32'h7fffffff) | {pc_q[31], 31'd0};

  always_comb begin
    next_pc = PCPlus4;
    if (exc_take) begin
      next_pc = EXC_VEC;
    end else if (Interrupt) begin
      next_pc = IRQ_VEC;
    end else begin
      case (PCSrc)
        SRC_SEQ:    next_pc = PCPlus4;
        SRC_BRANCH: next_pc = BranchCond ? br_target : PCPlus4;
        SRC_JUMP:   next_pc = {pc_q[31:28], JTarget, 2'b00};
        SRC_JR:     next_pc = RsData;
        default:    next_pc = PCPlus4;
      endcase
    end
  end

  always_comb begin
    pc_d = pc_q;
    if (!Stall) begin
      pc_d = next_pc & ~32'd3;
    end
  end

  // Interrupt already implies no stall; a new request on the same edge wins.
  always_comb begin
    irq_pend_d = irq_pend_q;
    if (Interrupt) begin
      irq_pend_d = 1'b0;
    end
    if (IRQ) begin
      irq_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_VEC;
      irq_pend_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      irq_pend_q <= irq_pend_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_unit
// Brief    : Table-driven, directed and randomized checks of pc_unit.
// Revision : 1.0
// ============================================================================
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset, Stall, BranchCond, IRQ, Exception;
  logic [1:0]  PCSrc;
  logic [15:0] Imm16;
  logic [25:0] JTarget;
  logic [31:0] RsData;
  logic [31:0] PC, PCPlus4;
  logic        pchigh, Interrupt;

  int n_chk  = 0;
  int n_fail = 0;

  pc_unit dut (
    .clk(clk), .reset(reset), .Stall(Stall), .PCSrc(PCSrc),
    .BranchCond(BranchCond), .Imm16(Imm16), .JTarget(JTarget),
    .RsData(RsData), .IRQ(IRQ), .Exception(Exception),
    .PC(PC), .PCPlus4(PCPlus4), .pchigh(pchigh), .Interrupt(Interrupt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic [1:0]  src;
    logic        bc;
    logic [15:0] imm;
    logic [25:0] jt;
    logic [31:0] rs;
    logic        irq;
    logic        exc;
    logic        exp_int;
    logic [31:0] exp_pc;
  } step_t;

  step_t tbl[$];

  task automatic add(input logic st, input logic [1:0] src, input logic bc,
                     input logic [15:0] imm, input logic [25:0] jt,
                     input logic [31:0] rs, input logic irq, input logic exc,
                     input logic ei, input logic [31:0] ep);
    step_t s;
    s.stall = st; s.src = src; s.bc = bc; s.imm = imm; s.jt = jt; s.rs = rs;
    s.irq = irq; s.exc = exc; s.exp_int = ei; s.exp_pc = ep;
    tbl.push_back(s);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    Stall = 1'b0; PCSrc = 2'b00; BranchCond = 1'b0; Imm16 = 16'h0;
    JTarget = 26'h0; RsData = 32'h0; IRQ = 1'b0; Exception = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic jr(input logic [31:0] a);
    PCSrc = 2'b11; RsData = a;
    tick();
    PCSrc = 2'b00; RsData = 32'h0;
  endtask

  // Reference model: arithmetic on the architectural rules.
  function automatic logic [31:0] inc(input logic [31:0] p);
    longint unsigned v;
    v = ((longint'(p) & 64'h7fffffff) + 4) % 64'h80000000;
    return (p & 32'h80000000) | 32'(v);
  endfunction

  function automatic logic [31:0] br(input logic [31:0] p, input logic [15:0] imm);
    longint v;
    v = (longint'(inc(p)) & 64'h7fffffff) + longint'($signed(imm)) * 4;
    v = v & 64'h7fffffff;
    return (p & 32'h80000000) | 32'(v);
  endfunction

  logic [31:0] m_pc, m_nxt;
  logic        m_pend, m_int, m_kern;

  initial begin
    reset = 1'b0;
    idle();

    // ---- reset state ----
    do_reset();
    #1;
    chk("reset_pc", PC, 32'h80000000);
    chk("reset_pcplus4", PCPlus4, 32'h80000004);
    chk("reset_pchigh", {31'd0, pchigh}, 32'd1);
    chk("reset_int", {31'd0, Interrupt}, 32'd0);

    // ---- table: one clock per step, starting from reset ----
    add(1'b0, 2'b00, 1'b0, 16'h0,    26'h0,       32'h0,        1'b0, 1'b0, 1'b0, 32'h80000004);
    add(1'b0, 2'b00, 1'b0, 16'h0,    26'h0,       32'h0,        1'b0, 1'b0, 1'b0, 32'h80000008);
    add(1'b0, 2'b00, 1'b0, 16'h0,    26'h0,       32'h0,        1'b0, 1'b0, 1'b0, 32'h8000000C);
    add(1'b0, 2'b11, 1'b0, 16'h0,    26'h0,       32'h00400013, 1'b0, 1'b0, 1'b0, 32'h00400010);
    add(1'b0, 2'b01, 1'b1, 16'hFFFC, 26'h0,       32'h0,        1'b0, 1'b0, 1'b0, 32'h00400004);
    add(1'b0, 2'b10, 1'b0, 16'h0,    26'h0100000, 32'h0,        1'b0, 1'b0, 1'b0, 32'h00400000);
    add(1'b0, 2'b01, 1'b0, 16'h0005, 26'h0,       32'h0,        1'b0, 1'b0, 1'b0, 32'h00400004);
    add(1'b0, 2'b00, 1'b0, 16'h0,    26'h0,       32'h0,        1'b0, 1'b1, 1'b0, 32'h80000008);
    add(1'b0, 2'b00, 1'b0, 16'h0,    26'h0,       32'h0,        1'b0, 1'b1, 1'b0, 32'h8000000C);
    add(1'b0, 2'b00, 1'b0, 16'h0,    26'h0,       32'h0,        1'b1, 1'b0, 1'b0, 32'h80000010);
    add(1'b0, 2'b11, 1'b0, 16'h0,    26'h0,       32'h00400000, 1'b0, 1'b0, 1'b0, 32'h00400000);
    add(1'b0, 2'b00, 1'b0, 16'h0,    26'h0,       32'h0,        1'b0, 1'b0, 1'b1, 32'h80000004);
    add(1'b0, 2'b11, 1'b0, 16'h0,    26'h0,       32'h00400100, 1'b0, 1'b0, 1'b0, 32'h00400100);
    add(1'b1, 2'b00, 1'b0, 16'h0,    26'h0,       32'h0,        1'b1, 1'b0, 1'b0, 32'h00400100);
    add(1'b1, 2'b00, 1'b0, 16'h0,    26'h0,       32'h0,        1'b0, 1'b0, 1'b0, 32'h00400100);
    add(1'b0, 2'b00, 1'b0, 16'h0,    26'h0,       32'h0,        1'b0, 1'b0, 1'b1, 32'h80000004);
    add(1'b0, 2'b01, 1'b1, 16'h7FFF, 26'h0,       32'h0,        1'b0, 1'b0, 1'b0, 32'h80020004);
    add(1'b0, 2'b00, 1'b0, 16'h0,    26'h0,       32'h0,        1'b0, 1'b0, 1'b0, 32'h80020008);
    add(1'b0, 2'b10, 1'b0, 16'h0,    26'h3FFFFFF, 32'h0,        1'b0, 1'b0, 1'b0, 32'h8FFFFFFC);
    add(1'b0, 2'b00, 1'b0, 16'h0,    26'h0,       32'h0,        1'b0, 1'b0, 1'b0, 32'h90000000);
    add(1'b0, 2'b11, 1'b0, 16'h0,    26'h0,       32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFC);
    add(1'b0, 2'b00, 1'b0, 16'h0,    26'h0,       32'h0,        1'b0, 1'b0, 1'b0, 32'h80000000);
    add(1'b0, 2'b11, 1'b0, 16'h0,    26'h0,       32'h7FFFFFFE, 1'b0, 1'b0, 1'b0, 32'h7FFFFFFC);
    add(1'b0, 2'b00, 1'b0, 16'h0,    26'h0,       32'h0,        1'b0, 1'b0, 1'b0, 32'h00000000);

    foreach (tbl[i]) begin
      Stall = tbl[i].stall; PCSrc = tbl[i].src; BranchCond = tbl[i].bc;
      Imm16 = tbl[i].imm; JTarget = tbl[i].jt; RsData = tbl[i].rs;
      IRQ = tbl[i].irq; Exception = tbl[i].exc;
      #1;
      chk($sformatf("tbl%0d_int", i), {31'd0, Interrupt}, {31'd0, tbl[i].exp_int});
      tick();
      chk($sformatf("tbl%0d_pc", i), PC, tbl[i].exp_pc);
      chk($sformatf("tbl%0d_pchigh", i), {31'd0, pchigh}, {31'd0, tbl[i].exp_pc[31]});
    end
    idle();

    // ---- exception and pending interrupt together; exception goes first ----
    do_reset();
    jr(32'h00400000);
    Stall = 1'b1; IRQ = 1'b1;
    tick();
    Stall = 1'b0; IRQ = 1'b0; Exception = 1'b1;
    #1;
    chk("simul_int_masked", {31'd0, Interrupt}, 32'd0);
    tick();
    chk("simul_pc_exc", PC, 32'h80000008);
    Exception = 1'b0;
    jr(32'h00400000);
    #1;
    chk("simul_pend_kept", {31'd0, Interrupt}, 32'd1);
    // reset while the interrupt is pending
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset_pc", PC, 32'h80000000);
    jr(32'h00400000);
    #1;
    chk("midreset_no_int", {31'd0, Interrupt}, 32'd0);
    tick();
    chk("midreset_seq", PC, 32'h00400004);

    // ---- set wins over clear on the accepting edge ----
    Stall = 1'b1; IRQ = 1'b1;
    tick();
    Stall = 1'b0;
    #1;
    chk("setwin_int", {31'd0, Interrupt}, 32'd1);
    tick();
    IRQ = 1'b0;
    chk("setwin_pc", PC, 32'h80000004);
    jr(32'h00400000);
    #1;
    chk("setwin_pend_kept", {31'd0, Interrupt}, 32'd1);

    // ---- reset overrides stall, IRQ and exception ----
    reset = 1'b1; Stall = 1'b1; IRQ = 1'b1; Exception = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    chk("rstovr_pc", PC, 32'h80000000);
    jr(32'h00400000);
    #1;
    chk("rstovr_no_int", {31'd0, Interrupt}, 32'd0);

    // ---- randomized run against the reference model ----
    do_reset();
    m_pc = 32'h80000000; m_pend = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      reset      = ($urandom_range(63) == 0);
      Stall      = ($urandom_range(3) == 0);
      PCSrc      = 2'($urandom_range(3));
      BranchCond = 1'($urandom_range(1));
      Imm16      = 16'($urandom);
      JTarget    = 26'($urandom);
      RsData     = $urandom;
      IRQ        = ($urandom_range(7) == 0);
      Exception  = ($urandom_range(7) == 0);
      m_kern = m_pc[31];
      m_int  = m_pend && !m_kern && !Exception && !Stall;
      #1;
      chk("rnd_int", {31'd0, Interrupt}, {31'd0, m_int});
      chk("rnd_pcplus4", PCPlus4, inc(m_pc));
      chk("rnd_pchigh", {31'd0, pchigh}, {31'd0, m_kern});
      if (reset) begin
        m_pc = 32'h80000000; m_pend = 1'b0;
      end else begin
        if (!Stall) begin
          if (Exception && !m_kern)  m_nxt = 32'h80000008;
          else if (m_int)            m_nxt = 32'h80000004;
          else if (PCSrc == 2'b01)   m_nxt = BranchCond ? br(m_pc, Imm16) : inc(m_pc);
          else if (PCSrc == 2'b10)   m_nxt = (m_pc & 32'hF0000000) | (32'(JTarget) * 4);
          else if (PCSrc == 2'b11)   m_nxt = RsData;
          else                       m_nxt = inc(m_pc);
          m_pc = m_nxt & 32'hFFFFFFFC;
        end
        if (IRQ)        m_pend = 1'b1;
        else if (m_int) m_pend = 1'b0;
      end
      tick();
      chk("rnd_pc", PC, m_pc);
    end
    reset = 1'b0;
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
